kb_color_ctrl: RTL and testbench

//  Sequences the keyboard-to-colour lookup. Decodes the PS/2 scan-code byte

---
 rtl/kb_color_ctrl.sv | 133 +++++++++++++
 tb/tb_kb_color_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_color_ctrl.sv
// kb_color_ctrl: PS/2 scan-code decoder feeding a frame-synchronous colour code.
// Decodes make / E0-extended / F0-break sequences, tracks the held key and
// presents the latest make code to the colour lookup only on frame_tick.
// Optional feature macro: KB_RELEASE_CLEAR_EN (releasing the held key reverts
// the displayed code to 8'h00 on the next frame tick).
module kb_color_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       frame_tick,
  output logic [7:0] kb_code,
  output logic       ext_flag,
  output logic       key_held,
  output logic       code_changed,
  output logic [7:0] err_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   to_cnt;
  logic [8:0]      pending;
  logic            pend_valid;
  logic [8:0]      held;

  logic            is_make;
  logic            is_break;
  logic            is_err;
  logic            dec_ext;
  logic            timeout;
  logic            brk_match;
  logic            is_prefix;

  assign is_prefix = (byte_in == B_EXT) || (byte_in == B_BRK);
  assign timeout   = (state != S_IDLE) && !byte_valid &&
                     (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign brk_match = is_break && key_held && ({dec_ext, byte_in} == held);

  // Decode the current byte against the prefix state
  always_comb begin
    next_state = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    is_err     = 1'b0;
    dec_ext    = 1'b0;
    if (byte_valid) begin
      unique case (state)
        S_IDLE: begin
          if (byte_in == B_EXT)      next_state = S_EXT;
          else if (byte_in == B_BRK) next_state = S_BRK;
          else                       is_make = 1'b1;
        end
        S_EXT: begin
          dec_ext = 1'b1;
          if (byte_in == B_BRK)      next_state = S_EXT_BRK;
          else if (byte_in == B_EXT) next_state = S_EXT;
          else begin
            is_make    = 1'b1;
            next_state = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          dec_ext    = (state == S_EXT_BRK);
          next_state = S_IDLE;
          if (is_prefix) is_err   = 1'b1;
          else           is_break = 1'b1;
        end
        default: next_state = S_IDLE;
      endcase
    end else if (timeout) begin
      next_state = S_IDLE;
      is_err     = 1'b1;
    end
  end

  // Prefix FSM, inter-byte timeout counter and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      to_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE || byte_valid || timeout) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + 1'b1;
      if (is_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Pending code, held-key tracking and frame-synchronous display update
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      pend_valid   <= 1'b0;
      held         <= '0;
      key_held     <= 1'b0;
      kb_code      <= '0;
      ext_flag     <= 1'b0;
      code_changed <= 1'b0;
    end else begin
      code_changed <= 1'b0;
      // Tick consumes the old pending value; a same-cycle make below re-arms it.
      if (frame_tick && pend_valid) begin
        {ext_flag, kb_code} <= pending;
        pend_valid          <= 1'b0;
        code_changed        <= (pending != {ext_flag, kb_code});
      end
      if (is_make) begin
        pending    <= {dec_ext, byte_in};
        pend_valid <= 1'b1;
        held       <= {dec_ext, byte_in};
        key_held   <= 1'b1;
      end else if (brk_match) begin
        key_held <= 1'b0;
`ifdef KB_RELEASE_CLEAR_EN
        pending    <= '0;
        pend_valid <= 1'b1;
`else
        pending    <= pending;
`endif
      end
    end
  end

endmodule

// File: tb/tb_kb_color_ctrl.sv
// Testbench for kb_color_ctrl: directed scenarios plus randomized byte/tick
// traffic, checked against a prefix-flag reference model of the decoder.
module tb_kb_color_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] kb_code;
  logic       ext_flag;
  logic       key_held;
  logic       code_changed;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;

  kb_color_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_tick(frame_tick), .kb_code(kb_code), .ext_flag(ext_flag),
    .key_held(key_held), .code_changed(code_changed), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: prefix flags seen so far, idle count, pending/display
  bit       pre_ext, pre_brk;
  int       idle;
  bit [8:0] m_pend, m_disp, m_held;
  bit       m_pv, m_kh, m_chg;
  int       m_err;

  function automatic logic [18:0] obs();
    return {kb_code, ext_flag, key_held, code_changed, err_cnt};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {m_disp[7:0], m_disp[8], m_kh, m_chg, 8'(m_err)};
  endfunction

  function automatic void model_reset();
    pre_ext = 0; pre_brk = 0; idle = 0;
    m_pend = 0; m_disp = 0; m_held = 0; m_pv = 0; m_kh = 0; m_chg = 0; m_err = 0;
  endfunction

  function automatic void add_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(bit v, bit [7:0] b, bit t);
    bit [8:0] key;
    m_chg = 0;
    if (t && m_pv) begin
      m_chg  = (m_pend != m_disp);
      m_disp = m_pend;
      m_pv   = 0;
    end
    if (v) begin
      idle = 0;
      key  = {pre_ext, b};
      if (pre_brk) begin
        if (b == 8'hE0 || b == 8'hF0) add_err();
        else if (m_kh && key == m_held) begin
          m_kh = 0;
`ifdef KB_RELEASE_CLEAR_EN
          m_pend = 0; m_pv = 1;
`endif
        end
        pre_ext = 0; pre_brk = 0;
      end else if (b == 8'hF0) pre_brk = 1;
      else if (b == 8'hE0) pre_ext = 1;
      else begin
        m_pend = key; m_pv = 1; m_held = key; m_kh = 1;
        pre_ext = 0;
      end
    end else if (pre_ext || pre_brk) begin
      idle++;
      if (idle == TO) begin
        add_err(); pre_ext = 0; pre_brk = 0; idle = 0;
      end
    end
  endfunction

  // One clock with the given inputs; model advanced with the same inputs
  task automatic cyc(bit v, bit [7:0] b, bit t);
    byte_valid = v; byte_in = b; frame_tick = t;
    @(posedge clk); #1;
    model_step(v, b, t);
    byte_valid = 0; frame_tick = 0;
  endtask

  task automatic do_reset();
    rst = 1; byte_valid = 0; frame_tick = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 19'd0) begin
      failures++; $display("FAIL reset_state got=%h want=%h", obs(), 19'd0);
    end
  endtask

  // Scenarios 1 and 2: make, tick, then break of the same key
  task automatic test_make_break();
    do_reset();
    cyc(1, 8'h1C, 0);
    checks++;
    if (key_held !== 1'b1 || kb_code !== 8'h00) begin
      failures++; $display("FAIL make_pre_tick got=%b/%h want=1/00", key_held, kb_code);
    end
    cyc(0, 0, 1);
    checks++;
    if ({kb_code, ext_flag, code_changed, key_held} !== {8'h1C, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL make_tick got=%h want=%h",
                           {kb_code, ext_flag, code_changed, key_held}, {8'h1C, 3'b011});
    end
    cyc(0, 0, 0);
    checks++;
    if (code_changed !== 1'b0) begin
      failures++; $display("FAIL changed_one_cycle got=%b want=0", code_changed);
    end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h1C, 0);
    checks++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL break_clears got=%b want=0", key_held);
    end
    cyc(0, 0, 1);
    checks++;
`ifdef KB_RELEASE_CLEAR_EN
    if ({kb_code, code_changed} !== {8'h00, 1'b1}) begin
      failures++; $display("FAIL break_tick got=%h want=%h", {kb_code, code_changed}, {8'h00, 1'b1});
    end
`else
    if ({kb_code, code_changed} !== {8'h1C, 1'b0}) begin
      failures++; $display("FAIL break_tick got=%h want=%h", {kb_code, code_changed}, {8'h1C, 1'b0});
    end
`endif
    checks++;
    if (obs() !== exp_vec()) begin
      failures++; $display("FAIL make_break_model got=%h want=%h", obs(), exp_vec());
    end
  endtask

  // Scenario 3: dangling E0 times out after exactly TO idle cycles
  task automatic test_timeout();
    do_reset();
    cyc(1, 8'hE0, 0);
    repeat (TO - 1) cyc(0, 0, 0);
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++; $display("FAIL timeout_early got=%0d want=0", err_cnt);
    end
    cyc(0, 0, 0);
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++; $display("FAIL timeout_err got=%0d want=1", err_cnt);
    end
    cyc(1, 8'h32, 0);
    cyc(0, 0, 1);
    checks++;
    if ({kb_code, ext_flag} !== {8'h32, 1'b0}) begin
      failures++; $display("FAIL timeout_then_make got=%h want=%h", {kb_code, ext_flag}, {8'h32, 1'b0});
    end
    cyc(1, 8'hE0, 0);
    cyc(1, 8'h75, 0);
    cyc(0, 0, 1);
    checks++;
    if ({kb_code, ext_flag} !== {8'h75, 1'b1}) begin
      failures++; $display("FAIL ext_make got=%h want=%h", {kb_code, ext_flag}, {8'h75, 1'b1});
    end
  endtask

  // Scenarios 4 and 5: latest make wins; tick with same-cycle byte shows old value
  task automatic test_back_to_back();
    int pulses;
    do_reset();
    cyc(1, 8'h1C, 0);
    cyc(1, 8'h32, 0);
    pulses = 0;
    cyc(0, 0, 1);
    if (code_changed) pulses++;
    repeat (3) begin
      cyc(0, 0, 1);
      if (code_changed) pulses++;
    end
    checks++;
    if (kb_code !== 8'h32 || pulses != 1) begin
      failures++; $display("FAIL latest_wins got=%h/%0d want=32/1", kb_code, pulses);
    end
    do_reset();
    cyc(1, 8'h1C, 0);
    cyc(1, 8'h32, 1);
    checks++;
    if (kb_code !== 8'h1C) begin
      failures++; $display("FAIL tick_old_pending got=%h want=1c", kb_code);
    end
    cyc(0, 0, 1);
    checks++;
    if ({kb_code, code_changed} !== {8'h32, 1'b1}) begin
      failures++; $display("FAIL tick_new_pending got=%h want=%h", {kb_code, code_changed}, {8'h32, 1'b1});
    end
  endtask

  // Scenario 6: reset discards a partial prefix; F0 F0 is a protocol error
  task automatic test_reset_mid_seq();
    do_reset();
    cyc(1, 8'hF0, 0);
    do_reset();
    cyc(1, 8'h1C, 0);
    checks++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL reset_discards_prefix got=%b want=1", key_held);
    end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'hF0, 0);
    checks++;
    if (err_cnt !== 8'd1 || key_held !== 1'b1) begin
      failures++; $display("FAIL brk_brk_err got=%0d/%b want=1/1", err_cnt, key_held);
    end
  endtask

  // Saturation: error counter stops at FF
  task automatic test_saturate();
    do_reset();
    repeat (260) begin
      cyc(1, 8'hF0, 0);
      cyc(1, 8'hE0, 0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++; $display("FAIL err_saturate got=%h want=ff", err_cnt);
    end
  endtask

  // Randomized traffic compared every cycle against the model
  task automatic test_random();
    bit [7:0] pool [6];
    bit [7:0] b;
    int vpct;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C;
    pool[3] = 8'h32; pool[4] = 8'h5A; pool[5] = 8'h1C;
    do_reset();
    for (int blk = 0; blk < 16; blk++) begin
      vpct = (blk % 2 == 0) ? 60 : 4;
      for (int i = 0; i < 60; i++) begin
        b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
        cyc($urandom_range(0, 99) < vpct, b, $urandom_range(0, 99) < 20);
        checks++;
        if (obs() !== exp_vec()) begin
          failures++;
          $display("FAIL random blk=%0d i=%0d got=%h want=%h", blk, i, obs(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_timeout();
    test_back_to_back();
    test_reset_mid_seq();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
